// File: rtl/dct8_stream_core.sv
// dct8_stream_core: streaming 8-point orthonormal DCT-II with double-buffered input and serial output.
// Optional build macro DCT_ROUND_EN adds round-half-up before the output scaling shift.
module dct8_stream_core #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 12,
  parameter int OUT_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [2:0]               out_idx,
  output logic                     out_last
);

  localparam int AW = DATA_W + COEF_W + 3;
  localparam int SH = COEF_W - 2;
  localparam logic signed [AW:0] SAT_MAX = (AW+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [AW:0] SAT_MIN = (AW+1)'(-(64'sd1 <<< (OUT_W-1)));
`ifdef DCT_ROUND_EN
  localparam logic signed [AW:0] RND_ADD = (AW+1)'(64'sd1 <<< (COEF_W-3));
`else
  localparam logic signed [AW:0] RND_ADD = {(AW+1){1'b0}};
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DRAIN = 2'd2} state_t;

  // cos(m*pi/16) held at 2^15 scale, rescaled to 2^(COEF_W-3); c(0) folds into cos(pi/4). Valid for COEF_W <= 18.
  function automatic logic signed [COEF_W-1:0] rom_val(input int k, input int n);
    int   a;
    int   m;
    int   base;
    int   mag;
    int   sh;
    logic neg;
    a = ((32'sd2 * n + 32'sd1) * k) % 32'sd32;
    if (k == 32'sd0) begin
      m = 32'sd4;  neg = 1'b0;
    end else if (a <= 32'sd8) begin
      m = a;  neg = 1'b0;
    end else if (a <= 32'sd16) begin
      m = 32'sd16 - a;  neg = 1'b1;
    end else if (a <= 32'sd24) begin
      m = a - 32'sd16;  neg = 1'b1;
    end else begin
      m = 32'sd32 - a;  neg = 1'b0;
    end
    case (m)
      32'sd0:  base = 32'sd32768;
      32'sd1:  base = 32'sd32138;
      32'sd2:  base = 32'sd30274;
      32'sd3:  base = 32'sd27246;
      32'sd4:  base = 32'sd23170;
      32'sd5:  base = 32'sd18205;
      32'sd6:  base = 32'sd12540;
      32'sd7:  base = 32'sd6393;
      default: base = 32'sd0;
    endcase
    sh = 32'sd18 - COEF_W;
    if (sh > 32'sd0) mag = (base + (32'sd1 <<< (sh - 32'sd1))) >>> sh;
    else             mag = base;
    return neg ? COEF_W'(-mag) : COEF_W'(mag);
  endfunction

  logic signed [COEF_W-1:0] rom_s [8][8];
  logic signed [DATA_W-1:0] buf_r [8];
  logic signed [DATA_W-1:0] work_r [8];
  logic signed [AW-1:0]     acc_r [8];
  logic signed [OUT_W-1:0]  res_r [8];
  logic signed [AW-1:0]     sum_s [8];
  logic signed [AW:0]       shf_s [8];
  logic signed [OUT_W-1:0]  sat_s [8];
  logic [3:0]               count_r;
  logic [2:0]               n_r;
  state_t                   state_r;
  logic                     accept_s;
  logic                     capture_s;

  for (genvar gk = 0; gk < 8; gk++) begin : g_rom_k
    for (genvar gn = 0; gn < 8; gn++) begin : g_rom_n
      assign rom_s[gk][gn] = rom_val(gk, gn);
    end
  end

  assign in_ready  = (count_r < 4'd8);
  assign accept_s  = in_valid && in_ready;
  assign capture_s = (state_r == IDLE) && (count_r == 4'd8);

  // Eight parallel MACs plus the scale / round / saturate path for the final term.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      sum_s[k] = acc_r[k] + (AW'(work_r[n_r]) * AW'(rom_s[k][n_r]));
      shf_s[k] = ((AW+1)'(sum_s[k]) + RND_ADD) >>> SH;
      if (shf_s[k] > SAT_MAX)      sat_s[k] = OUT_W'(SAT_MAX);
      else if (shf_s[k] < SAT_MIN) sat_s[k] = OUT_W'(SAT_MIN);
      else                         sat_s[k] = OUT_W'(shf_s[k]);
    end
  end

  // Datapath storage: fill buffer, engine working copy, accumulators and results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        buf_r[i]  <= '0;
        work_r[i] <= '0;
        acc_r[i]  <= '0;
        res_r[i]  <= '0;
      end
    end else begin
      if (accept_s) buf_r[count_r[2:0]] <= in_data;
      if (capture_s) begin
        work_r <= buf_r;
        for (int i = 0; i < 8; i++) acc_r[i] <= '0;
      end else if (state_r == CALC) begin
        acc_r <= sum_s;
        if (n_r == 3'd7) res_r <= sat_s;
      end
    end
  end

  // Fill count, engine sequencing and the registered output stage; clr flushes all of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= 4'd0;
      state_r   <= IDLE;
      n_r       <= 3'd0;
      out_valid <= 1'b0;
      out_idx   <= 3'd0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      count_r   <= 4'd0;
      state_r   <= IDLE;
      n_r       <= 3'd0;
      out_valid <= 1'b0;
      out_idx   <= 3'd0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (capture_s)     count_r <= 4'd0;
      else if (accept_s) count_r <= count_r + 4'd1;
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            n_r     <= 3'd0;
            state_r <= CALC;
          end
        end
        CALC: begin
          n_r <= n_r + 3'd1;
          if (n_r == 3'd7) begin
            state_r   <= DRAIN;
            out_valid <= 1'b1;
            out_data  <= sat_s[0];
            out_idx   <= 3'd0;
            out_last  <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_idx == 3'd7) begin
              state_r   <= IDLE;
              out_valid <= 1'b0;
              out_idx   <= 3'd0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              out_idx  <= out_idx + 3'd1;
              out_data <= res_r[out_idx + 3'd1];
              out_last <= (out_idx == 3'd6);
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct8_stream_core.sv
// tb_dct8_stream_core: directed-vector bench for dct8_stream_core (default widths plus an OUT_W=9 copy).
module tb_dct8_stream_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [7:0] in_data = 8'sd0;
  logic in_ready, out_valid, out_last;
  logic signed [11:0] out_data;
  logic [2:0] out_idx;
  logic in_ready9, out_valid9, out_last9;
  logic signed [8:0] out_data9;
  logic [2:0] out_idx9;

  int ncmp = 0;
  int nerr = 0;

  // Blocks: const 10, const -128, impulse 2, impulse 100, alternating +/-10.
  int vec_tab [5][8] = '{'{10, 10, 10, 10, 10, 10, 10, 10},
                         '{-128, -128, -128, -128, -128, -128, -128, -128},
                         '{2, 0, 0, 0, 0, 0, 0, 0},
                         '{100, 0, 0, 0, 0, 0, 0, 0},
                         '{10, -10, 10, -10, 10, -10, 10, -10}};
`ifdef DCT_ROUND_EN
  int exp_tab [5][8] = '{'{28, 0, 0, 0, 0, 0, 0, 0},
                         '{-362, 0, 0, 0, 0, 0, 0, 0},
                         '{1, 1, 1, 1, 1, 1, 0, 0},
                         '{35, 49, 46, 42, 35, 28, 19, 10},
                         '{0, 5, 0, 6, 0, 9, 0, 26}};
`else
  int exp_tab [5][8] = '{'{28, 0, 0, 0, 0, 0, 0, 0},
                         '{-362, 0, 0, 0, 0, 0, 0, 0},
                         '{0, 0, 0, 0, 0, 0, 0, 0},
                         '{35, 49, 46, 41, 35, 27, 19, 9},
                         '{0, 5, 0, 6, 0, 8, 0, 25}};
`endif

  logic signed [11:0] got_d [8];
  logic signed [8:0]  got_9 [8];
  logic [2:0]         got_i [8];
  logic               got_l [8];
  int ncol;
  int first_wait;
  int ctl_diff;

  dct8_stream_core dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last));

  dct8_stream_core #(.OUT_W(9)) dut9 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready9),
    .in_data(in_data), .out_valid(out_valid9), .out_ready(out_ready),
    .out_data(out_data9), .out_idx(out_idx9), .out_last(out_last9));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int b, input int cnt);
    for (int n = 0; n < cnt; n++) begin
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = 8'(vec_tab[b][n]);
      while (!in_ready && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) begin
        ncmp++;
        nerr++;
        $display("FAIL feed_timeout: in_ready stayed %0b, expected 1", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic collect();
    int cyc;
    cyc = 0;
    ncol = 0;
    first_wait = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      got_d[k] = 'x;
      got_9[k] = 'x;
      got_i[k] = 'x;
      got_l[k] = 1'bx;
    end
    while (ncol < 8 && cyc < 300) begin
      if (out_valid9 !== out_valid || out_idx9 !== out_idx || out_last9 !== out_last || in_ready9 !== in_ready)
        ctl_diff++;
      if (out_valid) begin
        if (first_wait < 0) first_wait = cyc;
        got_d[ncol] = out_data;
        got_9[ncol] = out_data9;
        got_i[ncol] = out_idx;
        got_l[ncol] = out_last;
        ncol++;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    ncmp++; if (in_ready !== 1'b1)   begin nerr++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
    ncmp++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
    ncmp++; if (out_idx !== 3'd0)    begin nerr++; $display("FAIL reset_out_idx: got %0d, expected 0", out_idx); end
    ncmp++; if (out_last !== 1'b0)   begin nerr++; $display("FAIL reset_out_last: got %0b, expected 0", out_last); end
    ncmp++; if (out_data !== 12'sd0) begin nerr++; $display("FAIL reset_out_data: got %0d, expected 0", out_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_dc();
    feed(0, 8);
    collect();
    ncmp++; if (ncol != 8) begin nerr++; $display("FAIL dc_count: got %0d coefficients, expected 8", ncol); end
    ncmp++; if (first_wait != 9) begin nerr++; $display("FAIL dc_latency: got %0d cycles, expected 9", first_wait); end
    for (int k = 0; k < 8; k++) begin
      ncmp++;
      if (got_d[k] !== 12'(exp_tab[0][k]) || got_i[k] !== 3'(k) || got_l[k] !== (k == 7)) begin
        nerr++;
        $display("FAIL dc_k%0d: got %0d idx %0d last %0b, expected %0d idx %0d last %0b",
                 k, got_d[k], got_i[k], got_l[k], exp_tab[0][k], k, k == 7);
      end
    end
    ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL dc_valid_drop: got %0b, expected 0", out_valid); end
  endtask

  task automatic test_neg_sat();
    ctl_diff = 0;
    feed(1, 8);
    collect();
    ncmp++; if (ncol != 8) begin nerr++; $display("FAIL neg_count: got %0d coefficients, expected 8", ncol); end
    for (int k = 0; k < 8; k++) begin
      ncmp++;
      if (got_d[k] !== 12'(exp_tab[1][k]) || int'(got_9[k]) != ((k == 0) ? -256 : 0)) begin
        nerr++;
        $display("FAIL neg_k%0d: got %0d (out9 %0d), expected %0d (out9 %0d)",
                 k, got_d[k], got_9[k], exp_tab[1][k], (k == 0) ? -256 : 0);
      end
    end
    ncmp++; if (ctl_diff != 0) begin nerr++; $display("FAIL sat_ctl: got %0d control differences, expected 0", ctl_diff); end
  endtask

  task automatic test_impulse();
    for (int b = 2; b <= 4; b++) begin
      feed(b, 8);
      collect();
      ncmp++; if (ncol != 8) begin nerr++; $display("FAIL vec%0d_count: got %0d, expected 8", b, ncol); end
      for (int k = 0; k < 8; k++) begin
        ncmp++;
        if (got_d[k] !== 12'(exp_tab[b][k]) || got_i[k] !== 3'(k) || got_l[k] !== (k == 7)) begin
          nerr++;
          $display("FAIL vec%0d_k%0d: got %0d idx %0d last %0b, expected %0d idx %0d last %0b",
                   b, k, got_d[k], got_i[k], got_l[k], exp_tab[b][k], k, k == 7);
        end
      end
    end
  endtask

  task automatic test_stall();
    feed(3, 8);
    fork
      feed(4, 8);
      begin : stall_side
        int w;
        int bad;
        logic signed [11:0] d0;
        logic [2:0] i0;
        logic l0;
        out_ready = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
          tick();
          w++;
        end
        d0 = out_data;
        i0 = out_idx;
        l0 = out_last;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
          tick();
          if (out_valid !== 1'b1 || out_data !== d0 || out_idx !== i0 || out_last !== l0) bad++;
        end
        ncmp++; if (bad != 0) begin nerr++; $display("FAIL stall_hold: got %0d unstable cycles, expected 0", bad); end
        ncmp++;
        if (d0 !== 12'(exp_tab[3][0]) || i0 !== 3'd0 || l0 !== 1'b0) begin
          nerr++;
          $display("FAIL stall_first: got %0d idx %0d last %0b, expected %0d idx 0 last 0", d0, i0, l0, exp_tab[3][0]);
        end
      end
    join
    ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_in_ready: got %0b, expected 0", in_ready); end
    for (int b = 3; b <= 4; b++) begin
      collect();
      ncmp++; if (ncol != 8) begin nerr++; $display("FAIL stall_vec%0d_count: got %0d, expected 8", b, ncol); end
      for (int k = 0; k < 8; k++) begin
        ncmp++;
        if (got_d[k] !== 12'(exp_tab[b][k]) || got_i[k] !== 3'(k) || got_l[k] !== (k == 7)) begin
          nerr++;
          $display("FAIL stall_vec%0d_k%0d: got %0d idx %0d, expected %0d idx %0d", b, k, got_d[k], got_i[k], exp_tab[b][k], k);
        end
      end
    end
  endtask

  task automatic test_flush();
    int seen;
    feed(0, 5);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    ncmp++;
    if ({in_ready, out_valid, out_idx, out_last} !== 6'b100000 || out_data !== 12'sd0) begin
      nerr++;
      $display("FAIL rst_mid: got rdy %0b vld %0b idx %0d last %0b data %0d, expected 1 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, out_data);
    end
    feed(4, 8);
    collect();
    ncmp++; if (first_wait != 9) begin nerr++; $display("FAIL rst_latency: got %0d, expected 9", first_wait); end
    for (int k = 0; k < 8; k++) begin
      ncmp++;
      if (got_d[k] !== 12'(exp_tab[4][k]) || got_i[k] !== 3'(k)) begin
        nerr++;
        $display("FAIL rst_k%0d: got %0d idx %0d, expected %0d idx %0d", k, got_d[k], got_i[k], exp_tab[4][k], k);
      end
    end
    feed(3, 8);
    feed(2, 3);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 8'sd100;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    ncmp++;
    if ({in_ready, out_valid, out_idx, out_last} !== 6'b100000 || out_data !== 12'sd0) begin
      nerr++;
      $display("FAIL clr_state: got rdy %0b vld %0b idx %0d last %0b data %0d, expected 1 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, out_data);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    ncmp++; if (seen != 0) begin nerr++; $display("FAIL clr_stale: got %0d valid cycles, expected 0", seen); end
    feed(4, 8);
    collect();
    ncmp++; if (first_wait != 9) begin nerr++; $display("FAIL clr_latency: got %0d, expected 9", first_wait); end
    for (int k = 0; k < 8; k++) begin
      ncmp++;
      if (got_d[k] !== 12'(exp_tab[4][k]) || got_i[k] !== 3'(k)) begin
        nerr++;
        $display("FAIL clr_k%0d: got %0d idx %0d, expected %0d idx %0d", k, got_d[k], got_i[k], exp_tab[4][k], k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int order [3] = '{0, 4, 3};
    fork
      begin
        feed(0, 8);
        feed(4, 8);
        feed(3, 8);
      end
      begin
        for (int j = 0; j < 3; j++) begin
          collect();
          if (j > 0) begin
            ncmp++;
            if (first_wait != 9) begin nerr++; $display("FAIL b2b_gap%0d: got %0d cycles, expected 9", j, first_wait); end
          end
          for (int k = 0; k < 8; k++) begin
            ncmp++;
            if (got_d[k] !== 12'(exp_tab[order[j]][k]) || got_i[k] !== 3'(k) || got_l[k] !== (k == 7)) begin
              nerr++;
              $display("FAIL b2b_blk%0d_k%0d: got %0d idx %0d last %0b, expected %0d idx %0d last %0b",
                       j, k, got_d[k], got_i[k], got_l[k], exp_tab[order[j]][k], k, k == 7);
            end
          end
        end
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_diff = 0;
    test_reset();
    test_dc();
    test_neg_sat();
    test_impulse();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
